// File: rtl/fa_gates_pkg.sv
// Shared types for the gate-level full adder: the {cout,s} result pair
// and its cleared value, used by the optional output register.
package fa_gates_pkg;

    typedef struct packed {
        logic cout;
        logic s;
    } fa_result_t;

    localparam fa_result_t FA_RESULT_ZERO = '{cout: 1'b0, s: 1'b0};

endpackage

// File: rtl/fa_gates_half_adder.sv
// Gate-level half adder: sum = x ^ y, carry = x & y, built from primitives
// so that X on either input propagates exactly as the gates define.
module half_adder (
    input  logic x,
    input  logic y,
    output logic sum,
    output logic carry
);

    xor g_xor (sum, x, y);
    and g_and (carry, x, y);

endmodule

// File: rtl/fa_gates.sv
// Full adder from two half adders and an OR gate, with an optional
// output register (async active-high reset) selected by REGISTER_OUT.
module fa_gates
    import fa_gates_pkg::*;
#(
    parameter int unsigned REGISTER_OUT = 32'd0
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ha0_sum_s;
    logic ha0_carry_s;
    logic ha1_sum_s;
    logic ha1_carry_s;
    logic cout_s;

    half_adder u_ha0 (
        .x     (a),
        .y     (b),
        .sum   (ha0_sum_s),
        .carry (ha0_carry_s)
    );

    half_adder u_ha1 (
        .x     (ha0_sum_s),
        .y     (cin),
        .sum   (ha1_sum_s),
        .carry (ha1_carry_s)
    );

    // The two half-adder carries can never both be 1, so OR completes the carry.
    or g_or (cout_s, ha0_carry_s, ha1_carry_s);

    generate
        if (REGISTER_OUT != 32'd0) begin : g_reg
            fa_result_t res_d;
            fa_result_t res_q;

            // Next-state: capture the current gate-level result.
            always_comb begin
                res_d      = FA_RESULT_ZERO;
                res_d.cout = cout_s;
                res_d.s    = ha1_sum_s;
            end

            // Output register; reset clears any pending result immediately.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    res_q <= FA_RESULT_ZERO;
                end else begin
                    res_q <= res_d;
                end
            end

            assign s    = res_q.s;
            assign cout = res_q.cout;
        end else begin : g_comb
            // Clock and reset have no role on the purely combinational path.
            logic unused_s;
            assign unused_s = clk ^ rst;

            assign s    = ha1_sum_s;
            assign cout = cout_s;
        end
    endgenerate

endmodule

// File: tb/tb_fa_gates.sv
// Self-checking bench for fa_gates: one combinational and one registered
// instance share stimulus; expectations flow through a scoreboard queue.
module tb_fa_gates;

    logic clk;
    logic rst;
    logic a;
    logic b;
    logic cin;
    logic s_c;
    logic cout_c;
    logic s_r;
    logic cout_r;

    int n_compared;
    int n_mismatched;

    logic [1:0] exp_q[$];

    fa_gates #(.REGISTER_OUT(32'd0)) u_comb (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .s    (s_c),
        .cout (cout_c)
    );

    fa_gates #(.REGISTER_OUT(32'd1)) u_reg (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .cin  (cin),
        .s    (s_r),
        .cout (cout_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [1:0] fa_model(input logic [2:0] v);
        return {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

    task automatic check_eq(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] v);
        {a, b, cin} = v;
        exp_q.push_back(fa_model(v));
    endtask

    task automatic sb_check(input string tag, input logic [1:0] obs);
        logic [1:0] exp;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL %s: got %b expected <none queued>", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            check_eq(tag, obs, exp);
        end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst = 1'b1;
        {a, b, cin} = 3'b000;
        #2;
        check_eq("reset_reg", {cout_r, s_r}, 2'b00);
        @(negedge clk);
        rst = 1'b0;

        // Combinational truth-table sweep, 5 ns per input pattern.
        for (int i = 0; i < 8; i++) begin
            drive(3'(i));
            #1;
            sb_check($sformatf("comb_sweep[%0d]", i), {cout_c, s_c});
            #4;
        end

        // Carry chain: 1+0+1 then 1+1+1.
        drive(3'b101);
        #1;
        sb_check("carry_101", {cout_c, s_c});
        check_eq("carry_101_lit", {cout_c, s_c}, 2'b10);
        #4;
        drive(3'b111);
        #1;
        sb_check("carry_111", {cout_c, s_c});
        check_eq("carry_111_lit", {cout_c, s_c}, 2'b11);

        // Registered path: baseline zero, then latency of one edge.
        @(negedge clk);
        drive(3'b000);
        @(posedge clk);
        #1;
        sb_check("reg_base", {cout_r, s_r});
        @(negedge clk);
        drive(3'b110);
        #3;
        check_eq("lat_before_edge", {cout_r, s_r}, 2'b00);
        @(posedge clk);
        #1;
        sb_check("lat_after_edge", {cout_r, s_r});
        check_eq("lat_after_lit", {cout_r, s_r}, 2'b10);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(3'(i));
            @(posedge clk);
            #1;
            sb_check($sformatf("reg_sweep[%0d]", i), {cout_r, s_r});
        end

        // Hold: input changes between edges must not reach the register output.
        @(negedge clk);
        #1;
        drive(3'b000);
        #2;
        check_eq("hold_mid", {cout_r, s_r}, 2'b11);
        @(posedge clk);
        #1;
        sb_check("hold_next_edge", {cout_r, s_r});

        @(negedge clk);
        drive(3'b111);
        @(posedge clk);
        #1;
        sb_check("pre_rst_11", {cout_r, s_r});

        // Async reset pulse between edges.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_immediate", {cout_r, s_r}, 2'b00);
        check_eq("comb_ignores_rst", {cout_c, s_c}, 2'b11);
        @(posedge clk);
        #1;
        check_eq("rst_hold_edge", {cout_r, s_r}, 2'b00);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_eq("rst_release", {cout_r, s_r}, 2'b00);
        exp_q.push_back(fa_model(3'b111));
        @(posedge clk);
        #1;
        sb_check("rst_first_capture", {cout_r, s_r});

        // Reset just after a capture discards that result.
        @(negedge clk);
        drive(3'b001);
        @(posedge clk);
        #1;
        sb_check("pending_capture", {cout_r, s_r});
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_discard", {cout_r, s_r}, 2'b00);
        rst = 1'b0;
        #1;
        check_eq("rst_discard_after", {cout_r, s_r}, 2'b00);

        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
